// File: rtl/simple_bus_pkg.sv
// Shared types and defaults for the simple bus master.
package simple_bus_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  // Bus mode encoding; 2'b10 and 2'b11 are reserved and never driven.
  typedef enum logic [1:0] {
    MODE_READ  = 2'b00,
    MODE_WRITE = 2'b01
  } bus_mode_e;

  // Master transfer state machine.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } bus_state_e;

endpackage

// File: rtl/sb_timeout_ctr.sv
// Clearable, saturating cycle counter; done_o flags that TIMEOUT-1 has been reached.
module sb_timeout_ctr #(
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count enabled cycles, stop at CNT_MAX instead of wrapping; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/simple_bus_master.sv
// Single-transfer bus master: takes a user command, arbitrates for the bus,
// issues one read or write with a start pulse, and returns a response.
// data_out/data_oe/data_in are resolved onto the shared data line by the
// enclosing level, matching the master side of the simple_bus interface.
module simple_bus_master
  import simple_bus_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        mode,
  output logic              start,
  input  logic              rdy,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in
);

  bus_state_e        state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              req_q, req_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  bus_mode_e         mode_q, mode_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ctr_clr, ctr_en, ctr_done;

  sb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (ctr_clr),
    .en_i  (ctr_en),
    .done_o(ctr_done)
  );

  // Next-state and next-output decode; gnt/rdy are looked at only in REQ/WAIT
  // and take priority over a timeout landing in the same cycle.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    req_d       = req_q;
    start_d     = start_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_d        = wr_q;
    caddr_d     = caddr_q;
    wdata_d     = wdata_q;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d        = cmd_write;
          caddr_d     = cmd_addr;
          wdata_d     = cmd_wdata;
          req_d       = 1'b1;
          cmd_ready_d = 1'b0;
          ctr_clr     = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        ctr_en = 1'b1;
        if (gnt) begin
          start_d = 1'b1;
          addr_d  = caddr_q;
          mode_d  = wr_q ? MODE_WRITE : MODE_READ;
          if (wr_q) begin
            data_out_d = wdata_q;
            data_oe_d  = 1'b1;
          end
          state_d = ST_START;
        end else if (ctr_done) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_START: begin
        start_d = 1'b0;
        ctr_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        if (rdy || ctr_done) begin
          req_d       = 1'b0;
          data_oe_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !rdy;
          rsp_rdata_d = (rdy && !wr_q) ? data_in : '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer and frees the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      req_q       <= 1'b0;
      start_q     <= 1'b0;
      addr_q      <= '0;
      mode_q      <= MODE_READ;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      caddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      req_q       <= req_d;
      start_q     <= start_d;
      addr_q      <= addr_d;
      mode_q      <= mode_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wr_q        <= wr_d;
      caddr_q     <= caddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // cmd_ready is masked while reset is held so no command is taken during reset.
  assign cmd_ready = cmd_ready_q & ~rst;
  assign req       = req_q;
  assign start     = start_q;
  assign addr      = addr_q;
  assign mode      = mode_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
